// File: rtl/header_inserter_if.sv
// Avalon-ST style streaming interface (valid/ready, data, sop, eop, empty).
interface avalon_st_if #(
    parameter int DATA_WIDTH = 128
);
    localparam int EMPTY_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [EMPTY_W-1:0]    empty;

    modport master (output valid, data, sop, eop, empty, input ready);
    modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/header_inserter.sv
// Prepends a runtime-length header to each packet of an Avalon-ST stream.
// Optional HEADER_INSERTER_SEQ_NUM_EN stamps a packet sequence number into the last header word.
//
// state  | meaning
// IDLE   | waiting for sop; non-sop words are dropped and counted
// LATCH  | one cycle: capture header_data and clamped header_words
// HEADER | emit latched header words, payload stalled
// DATA   | combinational payload pass-through until eop handshake
module header_inserter #(
    parameter int DATA_WIDTH    = 128,
    parameter int MAX_HDR_WORDS = 4,
    parameter int CNT_WIDTH     = 16,
    localparam int LEN_W   = $clog2(MAX_HDR_WORDS + 1),
    localparam int HDR_W   = MAX_HDR_WORDS * DATA_WIDTH,
    localparam int EMPTY_W = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           data_in,
    avalon_st_if.master          data_out,
    input  logic [HDR_W-1:0]     header_data,
    input  logic [LEN_W-1:0]     header_words,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        HEADER = 2'd2,
        DATA   = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [LEN_W-1:0]      k_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      len_in;
    logic [HDR_W-1:0]      hdr_q;
    logic                  first_q;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic                  last_hdr;
    logic                  drop;

    assign len_in   = (header_words > LEN_W'(MAX_HDR_WORDS)) ? LEN_W'(MAX_HDR_WORDS) : header_words;
    assign last_hdr = (k_q == len_q - LEN_W'(1));

`ifdef HEADER_INSERTER_SEQ_NUM_EN
    logic [CNT_WIDTH-1:0] seq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q <= '0;
        end else if (state_q == DATA && data_in.valid && data_out.ready && data_in.eop) begin
            seq_q <= seq_q + 1'b1;
        end
    end
`endif

    always_comb begin
        hdr_word = '0;
        for (int i = 0; i < MAX_HDR_WORDS; i++) begin
            if (k_q == LEN_W'(i)) begin
                hdr_word = hdr_q[(MAX_HDR_WORDS - i) * DATA_WIDTH - 1 -: DATA_WIDTH];
            end
        end
`ifdef HEADER_INSERTER_SEQ_NUM_EN
        if (last_hdr) begin
            hdr_word[CNT_WIDTH-1:0] = seq_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        drop           = 1'b0;
        data_in.ready  = 1'b0;
        data_out.valid = 1'b0;
        data_out.data  = '0;
        data_out.sop   = 1'b0;
        data_out.eop   = 1'b0;
        data_out.empty = '0;
        case (state_q)
            IDLE: begin
                // sop words are left on the bus so the packet starts only after the header is latched
                data_in.ready = ~data_in.sop;
                if (data_in.valid) begin
                    if (data_in.sop) begin
                        state_d = LATCH;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            LATCH: begin
                state_d = (len_in != '0) ? HEADER : DATA;
            end
            HEADER: begin
                data_out.valid = 1'b1;
                data_out.data  = hdr_word;
                data_out.sop   = (k_q == '0);
                if (data_out.ready && last_hdr) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                data_out.valid = data_in.valid;
                data_in.ready  = data_out.ready;
                data_out.data  = data_in.data;
                data_out.eop   = data_in.eop;
                data_out.empty = data_in.eop ? data_in.empty : '0;
                data_out.sop   = (len_q == '0) && first_q && data_in.sop;
                if (data_in.valid && data_out.ready && data_in.eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            data_in.ready  = 1'b0;
            data_out.valid = 1'b0;
            data_out.sop   = 1'b0;
            data_out.eop   = 1'b0;
            data_out.empty = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q      <= '0;
            len_q    <= '0;
            hdr_q    <= '0;
            first_q  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (drop && drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    hdr_q   <= header_data;
                    len_q   <= len_in;
                    first_q <= 1'b1;
                    k_q     <= '0;
                end
                HEADER: begin
                    if (data_out.ready && !last_hdr) begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DATA: begin
                    if (data_in.valid && data_out.ready) begin
                        first_q <= 1'b0;
                        if (data_in.eop) begin
                            k_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/header_inserter.md
HEADER_INSERTER -- requirements
Module: header_inserter

Interface
REQ-001 Parameter DATA_WIDTH, default 128: stream data width in bits, multiple of 8.
REQ-002 Parameter MAX_HDR_WORDS, default 4: maximum header length in DATA_WIDTH words, >= 1.
REQ-003 Parameter CNT_WIDTH, default 16: width of drop counter and packet sequence number, <= DATA_WIDTH.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_in  avalon_st_if slave  DATA_WIDTH  payload stream: valid, ready, data, sop, eop, empty.
REQ-007 data_out  avalon_st_if master  DATA_WIDTH  header + payload stream, same signal set.
REQ-008 header_data  input  MAX_HDR_WORDS*DATA_WIDTH  header; word k = bits [(MAX_HDR_WORDS-k)*DATA_WIDTH-1 -: DATA_WIDTH], word 0 sent first.
REQ-009 header_words  input  $clog2(MAX_HDR_WORDS+1)  runtime header length in words, 0..MAX_HDR_WORDS.
REQ-010 drop_cnt  output  CNT_WIDTH  count of input words discarded outside a packet.

Function
REQ-011 States: IDLE, LATCH, HEADER, DATA.
REQ-012 IDLE: data_in.ready=1 only for words without sop; data_out.valid=0.
REQ-013 IDLE, data_in.valid & sop: go to LATCH without consuming the word (ready=0 for sop words).
REQ-014 IDLE, data_in.valid & ~sop: word dropped; drop_cnt += 1, saturating at all-ones.
REQ-015 LATCH (one cycle): register header_data and min(header_words, MAX_HDR_WORDS); next state HEADER if length > 0, else DATA.
REQ-016 HEADER: data_out.valid=1 independent of data_in.valid; data = latched word k; sop=1 only for k=0; eop=0; empty=0; data_in.ready=0.
REQ-017 HEADER: k increments on data_out handshake; after word length-1 is accepted, go to DATA.
REQ-018 DATA: pure combinational pass-through: data_out.valid=data_in.valid, data_in.ready=data_out.ready, data/eop/empty forwarded; zero-cycle latency.
REQ-019 DATA: data_out.sop = data_in.sop only when length==0 and first payload word; otherwise 0 (input sop suppressed).
REQ-020 DATA: data_out.empty = data_in.empty when eop, else 0.
REQ-021 DATA: eop handshake returns to IDLE, k cleared; a single-word packet (sop & eop) completes DATA in one handshake.
REQ-022 Changes on header_data/header_words after LATCH do not affect the packet in flight.
REQ-023 data_out.valid never deasserts without a handshake once asserted in HEADER (Avalon-ST stability).

Reset
REQ-024 rst asserted: state IDLE, k=0, latched header and length 0, drop_cnt=0, sequence number 0, immediately and asynchronously.
REQ-025 Outputs under reset: data_out.valid=0, sop=0, eop=0, empty=0, data_in.ready=0.
REQ-026 Reset mid-packet abandons the packet; no eop is generated; first post-reset sop starts a fresh packet.

Configuration
REQ-027 Macro HEADER_INSERTER_SEQ_NUM_EN.
REQ-028 Defined: CNT_WIDTH-bit packet sequence counter; in the last header word, bits [CNT_WIDTH-1:0] are replaced by the counter; counter increments (wraps) on each eop handshake; no effect when length==0.
REQ-029 Undefined: header words sent exactly as latched; no sequence counter logic.

Verification
REQ-030 header_words=2, 3-word packet, data_out.ready=1: out = H0(sop), H1, D0, D1, D2(eop, empty copied); 1 LATCH bubble, 5 handshakes.
REQ-031 header_words=0, 1-word packet sop&eop, empty=5: out single word sop=1, eop=1, empty=5, data unchanged.
REQ-032 header_words=4, data_out.ready toggled 1/0 each cycle: header words held stable while ready=0; no word lost or duplicated.
REQ-033 Three non-sop words while IDLE: drop_cnt=3; data_out.valid stays 0.
REQ-034 rst pulsed during D1 of a packet: all outputs 0 next edge, drop_cnt=0; next packet starts with H0 sop.
REQ-035 SEQ_NUM_EN defined, header_words=1, CNT_WIDTH=16, three packets: H0 low bits 0x0000, 0x0001, 0x0002.
